input_debounce_ctrl: RTL and testbench



---
 rtl/input_debounce_ctrl_pkg.sv | 19 +
 rtl/input_debounce_ctrl_debounce_cell.sv | 70 +++++++
 rtl/input_debounce_ctrl.sv | 75 +++++++
 tb/tb_input_debounce_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/input_debounce_ctrl_pkg.sv
// Shared constants and types for the input-region front end.
// Address map of the 0x7800-0x781F input window and debounce FSM states.
package input_ctrl_pkg;

    localparam logic [15:0] INPUT_BASE  = 16'h7800;
    localparam logic [15:0] INPUT_LIMIT = 16'h781F;
    localparam logic [7:0]  BTN_OFFSET  = 8'h10;
    localparam logic [7:0]  PEND_OFFSET = 8'h14;

    typedef enum logic {
        DB_STABLE,
        DB_COUNT
    } debounce_state_e;

    function automatic logic in_input_region(input logic [15:0] addr);
        return (addr >= INPUT_BASE) && (addr <= INPUT_LIMIT);
    endfunction

endpackage

// File: rtl/input_debounce_ctrl_debounce_cell.sv
// Two-flop synchroniser plus counting debouncer for a WIDTH-bit group.
// The whole group commits together once it differs from S long enough.
module debounce_cell
    import input_ctrl_pkg::*;
#(
    parameter int              WIDTH           = 1,
    parameter int              DEBOUNCE_CYCLES = 50000,
    parameter logic [WIDTH-1:0] RESET_VAL      = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] stable,
    output logic [WIDTH-1:0] stable_nxt
);

    localparam int             CW   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] norm;
    logic [CW-1:0]    cnt;
    logic             diff;
    logic             commit;
    debounce_state_e  state;

    // RESET_VAL is the raw "released" level, so XOR yields active-high
    assign norm       = sync2 ^ RESET_VAL;
    assign diff       = (norm != stable);
    assign commit     = (state == DB_COUNT) && diff && (cnt == LAST);
    assign stable_nxt = commit ? norm : stable;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1  <= RESET_VAL;
            sync2  <= RESET_VAL;
            stable <= '0;
            cnt    <= '0;
            state  <= DB_STABLE;
        end else begin
            sync1  <= raw;
            sync2  <= sync1;
            stable <= stable_nxt;
            unique case (state)
                DB_STABLE: begin
                    if (diff) begin
                        state <= DB_COUNT;
                        cnt   <= cnt + 1'b1;
                    end else begin
                        cnt <= '0;
                    end
                end
                DB_COUNT: begin
                    if (!diff || commit) begin
                        state <= DB_STABLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= DB_STABLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/input_debounce_ctrl.sv
// Input-region front end: debounced switches/buttons and the W1C
// button-press pending register polled by firmware.
module input_debounce_ctrl
    import input_ctrl_pkg::*;
#(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter logic        BTN_ACTIVE_LOW  = 1'b1,
    parameter logic [15:0] PEND_ADDR       = 16'h7814
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_io_sw,
    input  logic [3:0]  i_io_btn,
    input  logic        i_st_en,
    input  logic [15:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_io_sw,
    output logic [3:0]  o_io_btn,
    output logic [3:0]  o_btn_pending,
    output logic        o_sw_changed
);

    localparam int DC = int'(DEBOUNCE_CYCLES);

    logic [31:0] sw_nxt;
    logic [3:0]  btn_nxt;
    logic [3:0]  btn_rise;
    logic [3:0]  clr;
    logic        pend_hit;
    logic        wdata_unused;

    debounce_cell #(
        .WIDTH          (32),
        .DEBOUNCE_CYCLES(DC),
        .RESET_VAL      (32'h0)
    ) u_sw (
        .clk       (i_clk),
        .reset     (i_reset),
        .raw       (i_io_sw),
        .stable    (o_io_sw),
        .stable_nxt(sw_nxt)
    );

    for (genvar k = 0; k < 4; k++) begin : g_btn
        debounce_cell #(
            .WIDTH          (1),
            .DEBOUNCE_CYCLES(DC),
            .RESET_VAL      (BTN_ACTIVE_LOW)
        ) u_btn (
            .clk       (i_clk),
            .reset     (i_reset),
            .raw       (i_io_btn[k]),
            .stable    (o_io_btn[k]),
            .stable_nxt(btn_nxt[k])
        );
    end

    // Press edges are seen on the commit edge itself, not a cycle later
    assign btn_rise     = btn_nxt & ~o_io_btn;
    assign pend_hit     = i_st_en && in_input_region(i_addr)
                          && (i_addr == PEND_ADDR);
    assign clr          = pend_hit ? i_wdata[3:0] : 4'h0;
    assign wdata_unused = ^i_wdata[31:4];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_btn_pending <= 4'h0;
            o_sw_changed  <= 1'b0;
        end else begin
            o_btn_pending <= (o_btn_pending & ~clr) | btn_rise;
            o_sw_changed  <= |(sw_nxt ^ o_io_sw);
        end
    end

endmodule

// File: tb/tb_input_debounce_ctrl.sv
// Directed and random checks of input_debounce_ctrl against a
// run-length reference model (DEBOUNCE_CYCLES=4, active-low buttons).
module tb_input_debounce_ctrl;

    localparam int DC = 4;

    logic        clk;
    logic        rst;
    logic [31:0] io_sw;
    logic [3:0]  io_btn;
    logic        st_en;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [31:0] sw_o;
    logic [3:0]  btn_o;
    logic [3:0]  pend_o;
    logic        chg_o;

    int tests = 0;
    int fails = 0;
    int pulses;

    // reference model state: raw history, committed values, mismatch runs
    logic [31:0] h_sw1, h_sw2;
    logic [3:0]  h_b1, h_b2;
    logic [31:0] m_sw;
    logic [3:0]  m_btn;
    logic [3:0]  m_pend;
    logic        m_chg;
    int          run_sw;
    int          run_b[4];

    input_debounce_ctrl #(
        .DEBOUNCE_CYCLES(16'd4),
        .BTN_ACTIVE_LOW (1'b1),
        .PEND_ADDR      (16'h7814)
    ) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_io_sw      (io_sw),
        .i_io_btn     (io_btn),
        .i_st_en      (st_en),
        .i_addr       (addr),
        .i_wdata      (wdata),
        .o_io_sw      (sw_o),
        .o_io_btn     (btn_o),
        .o_btn_pending(pend_o),
        .o_sw_changed (chg_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        logic [31:0] nsw;
        logic [3:0]  nb;
        logic [3:0]  rise;
        logic [3:0]  c;
        if (rst) begin
            h_sw1 = '0; h_sw2 = '0;
            h_b1 = 4'hF; h_b2 = 4'hF;
            m_sw = '0; m_btn = '0; m_pend = '0; m_chg = 1'b0;
            run_sw = 0;
            for (int k = 0; k < 4; k++) run_b[k] = 0;
            return;
        end
        nsw   = h_sw2;
        nb    = ~h_b2;
        m_chg = 1'b0;
        if (nsw != m_sw) begin
            run_sw++;
            if (run_sw == DC) begin
                m_chg  = (nsw != m_sw);
                m_sw   = nsw;
                run_sw = 0;
            end
        end else begin
            run_sw = 0;
        end
        rise = '0;
        for (int k = 0; k < 4; k++) begin
            if (nb[k] != m_btn[k]) begin
                run_b[k]++;
                if (run_b[k] == DC) begin
                    rise[k]  = nb[k];
                    m_btn[k] = nb[k];
                    run_b[k] = 0;
                end
            end else begin
                run_b[k] = 0;
            end
        end
        c = (st_en && addr == 16'h7814) ? wdata[3:0] : 4'h0;
        m_pend = (m_pend & ~c) | rise;
        h_sw2 = h_sw1; h_sw1 = io_sw;
        h_b2  = h_b1;  h_b1  = io_btn;
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        chk("m_sw", sw_o, m_sw);
        chk("m_btn", {28'h0, btn_o}, {28'h0, m_btn});
        chk("m_pend", {28'h0, pend_o}, {28'h0, m_pend});
        chk("m_chg", {31'h0, chg_o}, {31'h0, m_chg});
        pulses += int'(chg_o);
        st_en = 1'b0;
    endtask

    task automatic store(input logic [15:0] a, input logic [31:0] d);
        st_en = 1'b1;
        addr  = a;
        wdata = d;
        step();
    endtask

    initial begin
        int sw_hold;
        int btn_hold;
        rst = 1'b1; io_sw = '0; io_btn = 4'h0;
        st_en = 1'b0; addr = '0; wdata = '0;
        pulses = 0;

        repeat (3) begin
            step();
            chk("rst_btn", {28'h0, btn_o}, 32'h0);
            chk("rst_pend", {28'h0, pend_o}, 32'h0);
            chk("rst_sw", sw_o, 32'h0);
        end
        rst = 1'b0;
        repeat (5) step();
        chk("btn_before_6", {28'h0, btn_o}, 32'h0);
        step();
        chk("btn_after_6", {28'h0, btn_o}, 32'hF);
        chk("pend_first_press", {28'h0, pend_o}, 32'hF);

        io_btn = 4'hF;
        repeat (6) step();
        chk("btn_released", {28'h0, btn_o}, 32'h0);
        store(16'h7814, 32'hF);
        chk("pend_clear_all", {28'h0, pend_o}, 32'h0);

        io_sw  = 32'hA5A5_1234;
        pulses = 0;
        repeat (5) step();
        chk("sw_before_6", sw_o, 32'h0);
        step();
        chk("sw_after_6", sw_o, 32'hA5A5_1234);
        repeat (4) step();
        chk("sw_pulse_count", pulses, 1);

        repeat (5) begin
            io_btn = 4'hB;
            repeat (2) step();
            io_btn = 4'hF;
            repeat (2) step();
        end
        chk("bounce_btn", {28'h0, btn_o}, 32'h0);
        chk("bounce_pend", {28'h0, pend_o}, 32'h0);
        io_btn = 4'hB;
        repeat (10) step();
        chk("hold_btn2", {28'h0, btn_o}, 32'h4);
        chk("hold_pend2", {28'h0, pend_o}, 32'h4);

        io_btn = 4'hA;
        repeat (8) step();
        chk("pend_0101", {28'h0, pend_o}, 32'h5);
        store(16'h7814, 32'h0000_0004);
        chk("w1c_bit2", {28'h0, pend_o}, 32'h1);
        store(16'h7810, 32'h0000_000F);
        chk("other_addr", {28'h0, pend_o}, 32'h1);
        store(16'h7814, 32'hFFFF_FFF0);
        chk("upper_wdata", {28'h0, pend_o}, 32'h1);
        io_btn = 4'hF;
        repeat (8) step();
        chk("release_keeps", {28'h0, pend_o}, 32'h1);
        store(16'h7814, 32'hF);
        chk("pend_zero", {28'h0, pend_o}, 32'h0);

        io_btn = 4'hE;
        repeat (5) step();
        chk("collide_pre", {28'h0, pend_o}, 32'h0);
        store(16'h7814, 32'h1);
        chk("collide_btn", {28'h0, btn_o}, 32'h1);
        chk("collide_set", {28'h0, pend_o}, 32'h1);
        store(16'h7814, 32'h1);
        chk("collide_after", {28'h0, pend_o}, 32'h0);

        io_btn = 4'hF;
        repeat (8) step();
        io_sw = 32'h0000_00FF;
        repeat (4) step();
        pulses = 0;
        rst = 1'b1;
        step();
        chk("midrst_sw", sw_o, 32'h0);
        rst = 1'b0;
        repeat (5) step();
        chk("midrst_pre", sw_o, 32'h0);
        chk("midrst_nopulse", pulses, 0);
        step();
        chk("midrst_commit", sw_o, 32'h0000_00FF);
        repeat (3) step();
        chk("midrst_pulse", pulses, 1);

        sw_hold  = 0;
        btn_hold = 0;
        repeat (400) begin
            if (sw_hold == 0) begin
                if ($urandom_range(0, 3) == 0)
                    io_sw = $urandom;
                else
                    io_sw = io_sw ^ (32'h1 << $urandom_range(0, 31));
                sw_hold = $urandom_range(1, 8);
            end
            if (btn_hold == 0) begin
                io_btn   = 4'($urandom_range(0, 15));
                btn_hold = $urandom_range(1, 8);
            end
            sw_hold--;
            btn_hold--;
            if ($urandom_range(0, 5) == 0) begin
                st_en = 1'b1;
                addr  = ($urandom_range(0, 1) == 0) ? 16'h7814
                                                    : 16'($urandom);
                wdata = $urandom;
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
